// File: rtl/ssds_scan_controller_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Contents: digit/segment geometry, scan FSM state encoding, the latched
// per-slot payload, the pin bundle and a polarity helper for the pin stage.
package ssds_scan_controller_pkg;

    localparam int unsigned DIGIT_COUNT   = 4;
    localparam int unsigned SEG_WIDTH     = 7;
    localparam int unsigned BRIGHT_LEVELS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2,
        ST_OFF   = 2'd3
    } scan_state_t;

    // Captured at slot start so mid-slot input changes cannot tear the display.
    typedef struct packed {
        logic [SEG_WIDTH-1:0] seg;
        logic                 dp;
        logic [3:0]           brightness;
    } slot_t;

    // Logical (1 = asserted) view of the board pins.
    typedef struct packed {
        logic [SEG_WIDTH-1:0]   seg;
        logic                   dp;
        logic [DIGIT_COUNT-1:0] sel;
    } pins_t;

    // Map logical levels onto the board's electrical polarity.
    function automatic pins_t apply_polarity(input pins_t p, input logic active_low);
        return active_low ? pins_t'(~p) : p;
    endfunction

endpackage

// File: rtl/ssds_scan_controller_slot_timer.sv
// Loadable down-counter used to time the BLANK/ON/OFF phases.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   load        load load_value this cycle (wins over counting)
//   load_value  value to load; a phase of N cycles loads N-1
//   done_c      count has reached zero (combinational terminal-count flag)
module ssds_scan_controller_slot_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done_c
);

    logic [W-1:0] count;

    // Counts down to zero and holds there until reloaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/ssds_scan_controller.sv
// Time-multiplexes four 7-segment digits plus decimal points onto a shared
// segment bus with one-hot digit selects, a ghost-suppression blank at the
// start of every slot and 16-level brightness PWM inside each slot.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              scan enable; low forces IDLE with all pins inactive
//   digit_0..3      segment patterns {g..a}, 1 = lit
//   dots            decimal points, bit i belongs to digit i
//   brightness      ON steps per slot (0 = dark, 15 = 15/16 duty)
//   seg, dp, sel    registered board pins, polarity set by ACTIVE_LOW
//   frame_tick      one-cycle pulse with the first BLANK cycle of digit 0
//                   following a digit-3 slot
module ssds_scan_controller
    import ssds_scan_controller_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned STEP_CYCLES  = 1024,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [SEG_WIDTH-1:0]   digit_0,
    input  logic [SEG_WIDTH-1:0]   digit_1,
    input  logic [SEG_WIDTH-1:0]   digit_2,
    input  logic [SEG_WIDTH-1:0]   digit_3,
    input  logic [DIGIT_COUNT-1:0] dots,
    input  logic [3:0]             brightness,
    output logic [SEG_WIDTH-1:0]   seg,
    output logic                   dp,
    output logic [DIGIT_COUNT-1:0] sel,
    output logic                   frame_tick
);

    // Wide enough for the full PWM window; also covers an unusually long blank.
    localparam int unsigned PWM_W   = $clog2(BRIGHT_LEVELS * STEP_CYCLES + 1);
    localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam int unsigned CNT_W   = (PWM_W > BLANK_W) ? PWM_W : BLANK_W;

    localparam logic [CNT_W-1:0] STEP_LEN   = CNT_W'(STEP_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam pins_t            PINS_IDLE  = ACTIVE_LOW ? pins_t'('1) : pins_t'('0);

    scan_state_t state;
    logic [1:0]  digit_idx;
    slot_t       slot;
    pins_t       pins;

    logic             timer_load_c;
    logic [CNT_W-1:0] timer_value_c;
    logic             timer_done_c;
    logic [CNT_W-1:0] on_last_c;
    logic [CNT_W-1:0] off_last_c;
    logic [1:0]       cap_idx_c;
    slot_t            cap_slot_c;
    pins_t            on_pins_c;

    ssds_scan_controller_slot_timer #(
        .W (CNT_W)
    ) u_slot_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load_c),
        .load_value (timer_value_c),
        .done_c     (timer_done_c)
    );

    // Phase lengths minus one; on_last_c is only used when brightness is non-zero.
    always_comb begin
        on_last_c  = CNT_W'(slot.brightness) * STEP_LEN - CNT_W'(1);
        off_last_c = CNT_W'(5'(BRIGHT_LEVELS) - {1'b0, slot.brightness}) * STEP_LEN
                     - CNT_W'(1);
    end

    // Payload for the slot about to start: digit 0 from IDLE, else the next digit.
    always_comb begin
        cap_idx_c             = (state == ST_IDLE) ? 2'd0 : digit_idx + 2'd1;
        cap_slot_c.seg        = digit_0;
        cap_slot_c.dp         = dots[cap_idx_c];
        cap_slot_c.brightness = brightness;
        case (cap_idx_c)
            2'd1:    cap_slot_c.seg = digit_1;
            2'd2:    cap_slot_c.seg = digit_2;
            2'd3:    cap_slot_c.seg = digit_3;
            default: cap_slot_c.seg = digit_0;
        endcase
    end

    // Logical pin image for the ON phase of the current digit.
    always_comb begin
        on_pins_c     = '0;
        on_pins_c.seg = slot.seg;
        on_pins_c.dp  = slot.dp;
        on_pins_c.sel = 4'b0001 << digit_idx;
    end

    // Reload the timer on every phase change so it is aligned with state.
    always_comb begin
        timer_load_c  = 1'b0;
        timer_value_c = '0;
        if (en) begin
            case (state)
                ST_IDLE: begin
                    timer_load_c  = 1'b1;
                    timer_value_c = BLANK_LAST;
                end
                ST_BLANK: begin
                    timer_load_c  = timer_done_c;
                    timer_value_c = (slot.brightness == 4'd0) ? off_last_c : on_last_c;
                end
                ST_ON: begin
                    timer_load_c  = timer_done_c;
                    timer_value_c = off_last_c;
                end
                ST_OFF: begin
                    timer_load_c  = timer_done_c;
                    timer_value_c = BLANK_LAST;
                end
                default: begin
                    timer_load_c  = 1'b0;
                    timer_value_c = '0;
                end
            endcase
        end
    end

    // Scan FSM with registered pin stage; pins are only active while in ON.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            digit_idx  <= 2'd0;
            slot       <= '0;
            pins       <= PINS_IDLE;
            frame_tick <= 1'b0;
        end else if (!en) begin
            state      <= ST_IDLE;
            digit_idx  <= 2'd0;
            pins       <= PINS_IDLE;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state     <= ST_BLANK;
                    digit_idx <= 2'd0;
                    slot      <= cap_slot_c;
                    pins      <= PINS_IDLE;
                end
                ST_BLANK: begin
                    if (timer_done_c) begin
                        if (slot.brightness == 4'd0) begin
                            state <= ST_OFF;
                        end else begin
                            state <= ST_ON;
                            pins  <= apply_polarity(on_pins_c, ACTIVE_LOW);
                        end
                    end
                end
                ST_ON: begin
                    if (timer_done_c) begin
                        state <= ST_OFF;
                        pins  <= PINS_IDLE;
                    end
                end
                ST_OFF: begin
                    if (timer_done_c) begin
                        state      <= ST_BLANK;
                        digit_idx  <= digit_idx + 2'd1;
                        slot       <= cap_slot_c;
                        frame_tick <= (digit_idx == 2'd3);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    pins  <= PINS_IDLE;
                end
            endcase
        end
    end

    assign seg = pins.seg;
    assign dp  = pins.dp;
    assign sel = pins.sel;

endmodule

// File: tb/tb_ssds_scan_controller.sv
// Self-checking bench for ssds_scan_controller (BLANK=2, STEP=1, active-low).
// The reference model tracks position within an 18-cycle slot arithmetically
// and derives the expected pins from the latched slot payload.
module tb_ssds_scan_controller;

    localparam int BLANK = 2;
    localparam int STEP  = 1;
    localparam int SLOT  = BLANK + 16 * STEP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [6:0] digit_0 = '0, digit_1 = '0, digit_2 = '0, digit_3 = '0;
    logic [3:0] dots = '0, brightness = '0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] sel;
    logic       frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit         m_run   = 1'b0;
    int         m_t     = 0;
    int         m_d     = 0;
    bit         m_first = 1'b1;
    logic [6:0] m_seg   = '0;
    logic       m_dp    = 1'b0;
    int         m_b     = 0;
    logic [3:0] prev_sel = 4'hF;

    ssds_scan_controller #(
        .BLANK_CYCLES (BLANK),
        .STEP_CYCLES  (STEP),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit_0    (digit_0),
        .digit_1    (digit_1),
        .digit_2    (digit_2),
        .digit_3    (digit_3),
        .dots       (dots),
        .brightness (brightness),
        .seg        (seg),
        .dp         (dp),
        .sel        (sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pattern_of(input int d);
        case (d)
            1:       return digit_1;
            2:       return digit_2;
            3:       return digit_3;
            default: return digit_0;
        endcase
    endfunction

    task automatic model_latch();
        m_seg = pattern_of(m_d);
        m_dp  = dots[m_d];
        m_b   = int'(brightness);
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        if (rst || !en) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run   = 1'b1;
            m_t     = 0;
            m_d     = 0;
            m_first = 1'b1;
            model_latch();
        end else begin
            m_t++;
            if (m_t == SLOT) begin
                m_t     = 0;
                m_d     = (m_d + 1) % 4;
                m_first = 1'b0;
                model_latch();
            end
        end
    endtask

    task automatic check_cycle();
        bit         act;
        bit         ok;
        logic [3:0] onehot;
        logic [3:0] e_sel;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_ft;
        act    = m_run && (m_t >= BLANK) && (m_t < BLANK + m_b * STEP);
        onehot = 4'b0001 << m_d;
        e_sel  = act ? ~onehot : 4'hF;
        e_seg  = act ? ~m_seg : 7'h7F;
        e_dp   = act ? ~m_dp : 1'b1;
        e_ft   = m_run && (m_t == 0) && (m_d == 0) && !m_first;
        chk("model_pins", {19'd0, frame_tick, sel, seg, dp}, {19'd0, e_ft, e_sel, e_seg, e_dp});
        // At most one select asserted, and no direct hop between two digits.
        ok = ($countones(~sel) <= 1) &&
             !((prev_sel != 4'hF) && (sel != 4'hF) && (sel != prev_sel));
        chk("sel_onehot", 32'(ok), 32'd1);
        prev_sel = sel;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] b;
        logic [6:0] d0;
        logic [6:0] drest;
        logic [3:0] dt;
        int         k;
        logic [3:0] e_sel;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_ft;
    } vec_t;

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{4'd15, 7'h3F, 7'h00, 4'h0,  0, 4'hF, 7'h7F, 1'b1, 1'b0};
        vecs[1]  = '{4'd15, 7'h3F, 7'h00, 4'h0,  1, 4'hF, 7'h7F, 1'b1, 1'b0};
        vecs[2]  = '{4'd15, 7'h3F, 7'h00, 4'h0,  2, 4'hF, 7'h7F, 1'b1, 1'b0};
        vecs[3]  = '{4'd15, 7'h3F, 7'h00, 4'h0,  3, 4'hE, 7'h40, 1'b1, 1'b0};
        vecs[4]  = '{4'd15, 7'h3F, 7'h00, 4'h0, 17, 4'hE, 7'h40, 1'b1, 1'b0};
        vecs[5]  = '{4'd15, 7'h3F, 7'h00, 4'h0, 18, 4'hF, 7'h7F, 1'b1, 1'b0};
        vecs[6]  = '{4'd15, 7'h3F, 7'h00, 4'h0, 21, 4'hD, 7'h7F, 1'b1, 1'b0};
        vecs[7]  = '{4'd15, 7'h3F, 7'h00, 4'h0, 73, 4'hF, 7'h7F, 1'b1, 1'b1};
        vecs[8]  = '{4'd15, 7'h3F, 7'h00, 4'h0, 74, 4'hF, 7'h7F, 1'b1, 1'b0};
        vecs[9]  = '{4'd15, 7'h3F, 7'h00, 4'h1,  3, 4'hE, 7'h40, 1'b0, 1'b0};
        vecs[10] = '{4'd0,  7'h3F, 7'h00, 4'h0,  3, 4'hF, 7'h7F, 1'b1, 1'b0};
        vecs[11] = '{4'd0,  7'h3F, 7'h00, 4'h0, 73, 4'hF, 7'h7F, 1'b1, 1'b1};
        vecs[12] = '{4'd4,  7'h7F, 7'h7F, 4'h0,  6, 4'hE, 7'h00, 1'b1, 1'b0};
        vecs[13] = '{4'd4,  7'h7F, 7'h7F, 4'h0,  7, 4'hF, 7'h7F, 1'b1, 1'b0};
        vecs[14] = '{4'd4,  7'h7F, 7'h7F, 4'h0, 24, 4'hD, 7'h00, 1'b1, 1'b0};
        vecs[15] = '{4'd4,  7'h7F, 7'h7F, 4'h0, 42, 4'hB, 7'h00, 1'b1, 1'b0};
        vecs[16] = '{4'd4,  7'h7F, 7'h7F, 4'h0, 60, 4'h7, 7'h00, 1'b1, 1'b0};
        vecs[17] = '{4'd4,  7'h7F, 7'h7F, 4'h0, 61, 4'hF, 7'h7F, 1'b1, 1'b0};
        vecs[18] = '{4'd4,  7'h7F, 7'h7F, 4'h0, 75, 4'hE, 7'h00, 1'b1, 1'b0};

        // Fixed-input vectors, each from a fresh reset.
        for (int i = 0; i < 19; i++) begin
            brightness = vecs[i].b;
            digit_0    = vecs[i].d0;
            digit_1    = vecs[i].drest;
            digit_2    = vecs[i].drest;
            digit_3    = vecs[i].drest;
            dots       = vecs[i].dt;
            en         = 1'b1;
            do_reset();
            repeat (vecs[i].k) step();
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].e_sel));
            chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].e_seg));
            chk($sformatf("vec%0d_dp", i), 32'(dp), 32'(vecs[i].e_dp));
            chk($sformatf("vec%0d_ft", i), 32'(frame_tick), 32'(vecs[i].e_ft));
        end

        // Mid-slot pattern change must not tear the current slot.
        brightness = 4'd4;
        digit_0 = 7'h00; digit_1 = 7'h06; digit_2 = 7'h00; digit_3 = 7'h00;
        dots = 4'h0;
        en = 1'b1;
        do_reset();
        repeat (22) step();
        chk("tear_before_sel", 32'(sel), 32'hD);
        chk("tear_before_seg", 32'(seg), 32'h79);
        digit_1 = 7'h5B;
        repeat (2) step();
        chk("tear_hold_seg", 32'(seg), 32'h79);
        repeat (69) step();
        chk("tear_next_sel", 32'(sel), 32'hD);
        chk("tear_next_seg", 32'(seg), 32'h24);

        // en drop during digit 2 ON, then restart at digit 0.
        digit_0 = 7'h7F; digit_1 = 7'h7F; digit_2 = 7'h7F; digit_3 = 7'h7F;
        dots = 4'hF;
        do_reset();
        repeat (40) step();
        chk("en_on_sel", 32'(sel), 32'hB);
        chk("en_on_dp", 32'(dp), 32'h0);
        en = 1'b0;
        step();
        chk("en_off_sel", 32'(sel), 32'hF);
        chk("en_off_seg", 32'(seg), 32'h7F);
        chk("en_off_dp", 32'(dp), 32'h1);
        en = 1'b1;
        step();
        chk("en_restart_blank", 32'(sel), 32'hF);
        repeat (2) step();
        chk("en_restart_d0", 32'(sel), 32'hE);

        // Reset pulse mid-ON with en held high.
        do_reset();
        repeat (4) step();
        chk("rst_mid_on_sel", 32'(sel), 32'hE);
        rst = 1'b1;
        step();
        chk("rst_pulse_sel", 32'(sel), 32'hF);
        chk("rst_pulse_seg", 32'(seg), 32'h7F);
        rst = 1'b0;
        repeat (3) step();
        chk("rst_resume_sel", 32'(sel), 32'hE);

        // Randomised inputs, enable and reset against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) begin
                digit_0    = 7'($urandom);
                digit_1    = 7'($urandom);
                digit_2    = 7'($urandom);
                digit_3    = 7'($urandom);
                dots       = 4'($urandom);
                brightness = 4'($urandom);
            end
            if ($urandom_range(199) == 0) en = ~en;
            if (!en && $urandom_range(15) == 0) en = 1'b1;
            rst = ($urandom_range(499) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
